twos_comp_to_sign_mag: RTL and testbench
========================================

TWOS_COMP_TO_SIGN_MAG -- requirements
Module: twos_comp_to_sign_mag

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (minimum 2).
REQ-002 Parameter CNT_W, default 8, overflow event counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_data holds a valid two's-complement word.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  WIDTH  two's-complement operand (e.g. subtractor difference).
REQ-008 out_valid  output  1  out_data/out_ovf valid.
REQ-009 out_ready  input  1  downstream accepts output this cycle.
REQ-010 out_data  output  WIDTH  sign-magnitude result: MSB is sign, lower WIDTH-1 bits are magnitude.
REQ-011 out_ovf  output  1  result saturated; qualified by out_valid.
REQ-012 ovf_count  output  CNT_W  saturating count of overflowed words delivered.

Function
REQ-013 Transfer on the input occurs on a rising edge with in_valid && in_ready; transfer on the output occurs on a rising edge with out_valid && out_ready.
REQ-014 Two-stage pipeline: S1 registers the sign bit, a most-negative flag, and the bitwise inverse (if negative) or pass-through (if non-negative) of the lower WIDTH-1 bits; S2 adds the +1 correction for negative words and drives the outputs.
REQ-015 Latency is exactly 2 cycles from input transfer to out_valid with out_ready held high; throughput is 1 word/cycle.
REQ-016 Non-negative input (MSB=0): out_data = in_data, out_ovf = 0.
REQ-017 Negative input, not the most-negative value: out_data = {1'b1, magnitude}, where magnitude = -in_data truncated to WIDTH-1 bits; out_ovf = 0.
REQ-018 Most-negative input (1 followed by WIDTH-1 zeros) is unrepresentable: out_data = all ones (sign 1, maximum magnitude); out_ovf = 1.
REQ-019 The block never emits negative zero (sign 1 with magnitude 0).
REQ-020 Backpressure: a stage loads when it is empty or its contents advance in the same cycle.
REQ-021 in_ready = !S1_valid || (!S2_valid || out_ready); in_ready has no combinational path from in_valid.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_ovf are held stable and no word is dropped or duplicated.
REQ-023 Simultaneous input and output transfer with both stages full keeps the pipeline full with no bubble.
REQ-024 ovf_count increments by 1 on each output transfer with out_ovf=1, and saturates at all ones (no wrap-around).

Reset
REQ-025 On rst_n low, asynchronously: S1_valid=0, S2_valid=0, out_valid=0, out_data=0, out_ovf=0, ovf_count=0.
REQ-026 During reset, in_ready=0; it rises on the first cycle after rst_n deasserts.
REQ-027 Words in flight when reset is asserted are discarded; no output transfer occurs for them after reset.

Structure
REQ-028 A shared package holds the sign-magnitude packed struct typedef (sign, magnitude), the DATA_W=32 default constant, and a function that detects the most-negative value.
REQ-029 One sub-module, pipe_stage_reg, holds the valid/ready register slice; it is instantiated for S1 and S2.
REQ-030 Implementation size is 120-400 lines of RTL, with no latches and no multicycle paths.

Verification
REQ-031 in_data = 32'h00000005, out_ready=1 -> after 2 cycles out_data = 32'h00000005, out_ovf=0.
REQ-032 in_data = 32'hFFFFFFFE (-2) -> out_data = 32'h80000002; in_data = 32'hFFFFFFF9 (-7) -> out_data = 32'h80000007.
REQ-033 in_data = 32'h80000000 -> out_data = 32'hFFFFFFFF, out_ovf=1, ovf_count 0->1; 300 such transfers with CNT_W=8 -> ovf_count = 8'hFF.
REQ-034 Stream 0,1,-1,2 with out_ready low for 3 cycles mid-stream -> in_ready falls once both stages are full; output sequence is 0x0, 0x1, 0x80000001, 0x2 in order, with no loss and stable held data.
REQ-035 Assert rst_n low with both stages full -> out_valid=0 and ovf_count=0 immediately; no stale word appears after release.
REQ-036 in_data = 32'h00000000 and 32'h7FFFFFFF -> outputs 32'h00000000 and 32'h7FFFFFFF; no negative zero is ever observed.

Source files
------------

// File: rtl/twos_comp_to_sign_mag_pkg.sv
// Shared types, constants and helpers for the two's-complement to sign-magnitude converter.
package twos_comp_to_sign_mag_pkg;

  localparam int unsigned DATA_W = 32;

  // Widest word the most-negative detector can handle.
  localparam int unsigned MAX_W  = 128;
  localparam int unsigned MAX_IW = $clog2(MAX_W);

  // Sign-magnitude word at the default width.
  typedef struct packed {
    logic              sign;
    logic [DATA_W-2:0] mag;
  } sm_word_t;

  // True when the low w bits of v are 1 followed by w-1 zeros.
  function automatic logic is_most_neg(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] low_mask;
    low_mask = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    return v[MAX_IW'(w - 1)] && ((v & low_mask) == '0);
  endfunction

endpackage

// File: rtl/twos_comp_to_sign_mag_pipe_stage_reg.sv
// Valid/ready register slice: loads when empty or when its contents leave this cycle.
module pipe_stage_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  // Slot is free when empty or being drained in the same cycle.
  always_comb begin
    in_ready = !r_valid || out_ready;
    w_load   = in_valid && in_ready;
  end

  // Valid flag and payload; payload only changes on a load so held data stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (in_ready) r_valid <= in_valid;
      if (w_load)   r_data  <= in_data;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/twos_comp_to_sign_mag.sv
// Two-stage converter from two's-complement to sign-magnitude with saturation on the
// most-negative value and a saturating count of overflowed words delivered.
module twos_comp_to_sign_mag
  import twos_comp_to_sign_mag_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,  // 2..MAX_W
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  // S1 payload: {sign, most_neg, low bits (inverted when negative)}.
  localparam int unsigned S1_W = WIDTH + 1;
  // S2 payload: {ovf, sign-magnitude word}.
  localparam int unsigned S2_W = WIDTH + 1;

  logic             r_run;
  logic             w_s1_in_ready;
  logic             w_s1_in_valid;
  logic [S1_W-1:0]  w_s1_din;
  logic             w_s1_valid;
  logic [S1_W-1:0]  w_s1_q;
  logic             w_s2_in_ready;
  logic [S2_W-1:0]  w_s2_din;
  logic [S2_W-1:0]  w_s2_q;
  logic             w_sign;
  logic             w_most_neg;
  logic [WIDTH-2:0] w_low;
  logic [WIDTH-2:0] w_mag;
  logic             w_out_fire;
  logic [CNT_W-1:0] r_ovf_count;

  // Holds the input closed while in reset and opens it on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // S1 front end: capture sign, most-negative flag and conditionally inverted low bits.
  always_comb begin
    in_ready      = r_run && w_s1_in_ready;
    w_s1_in_valid = r_run && in_valid;
    w_s1_din      = {in_data[WIDTH-1],
                     is_most_neg(MAX_W'(in_data), WIDTH),
                     in_data[WIDTH-1] ? ~in_data[WIDTH-2:0] : in_data[WIDTH-2:0]};
  end

  pipe_stage_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_s1_in_valid),
    .in_ready  (w_s1_in_ready),
    .in_data   (w_s1_din),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_in_ready),
    .out_data  (w_s1_q)
  );

  // S2 front end: +1 correction for negatives; most-negative saturates to all ones.
  always_comb begin
    w_sign     = w_s1_q[WIDTH];
    w_most_neg = w_s1_q[WIDTH-1];
    w_low      = w_s1_q[WIDTH-2:0];
    w_mag      = w_sign ? (w_low + (WIDTH-1)'(1)) : w_low;
    w_s2_din   = {1'b0, w_sign, w_mag};
    if (w_most_neg) w_s2_din = {1'b1, {WIDTH{1'b1}}};
  end

  pipe_stage_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_in_ready),
    .in_data   (w_s2_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_q)
  );

  assign out_ovf    = w_s2_q[WIDTH];
  assign out_data   = w_s2_q[WIDTH-1:0];
  assign w_out_fire = out_valid && out_ready;

  // Saturating count of delivered overflow words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_out_fire && out_ovf && (r_ovf_count != {CNT_W{1'b1}})) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_twos_comp_to_sign_mag.sv
// Directed bench for twos_comp_to_sign_mag (WIDTH=32, CNT_W=8).
module tb_twos_comp_to_sign_mag;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [7:0]  ovf_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  twos_comp_to_sign_mag #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One word through an idle pipeline with out_ready high; checks 2-cycle latency and result.
  task automatic send_and_check(input logic [31:0] d, input logic [31:0] exp_d,
                                input logic exp_o);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency_not_early", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("out_valid_at_2", {31'b0, out_valid}, 32'd1);
    chk("out_data", out_data, exp_d);
    chk("out_ovf", {31'b0, out_ovf}, {31'b0, exp_o});
    if (exp_o && exp_cnt < 255) exp_cnt++;
    @(negedge clk);
    chk("drained", {31'b0, out_valid}, 32'd0);
    chk("ovf_count", {24'b0, ovf_count}, 32'(exp_cnt));
  endtask

  logic [31:0] stream_in  [4];
  logic [31:0] stream_exp [4];

  initial begin
    int sent, rcvd, cyc;
    logic held_v;
    logic [31:0] held_d;
    logic saw_stall;
    logic in_fire, out_fire;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    chk("rst_ovf_count", {24'b0, ovf_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Single-word conversions.
    send_and_check(32'h0000_0005, 32'h0000_0005, 1'b0);
    send_and_check(32'hFFFF_FFFE, 32'h8000_0002, 1'b0);
    send_and_check(32'hFFFF_FFF9, 32'h8000_0007, 1'b0);
    send_and_check(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    send_and_check(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    send_and_check(32'h0000_0000, 32'h0000_0000, 1'b0);
    send_and_check(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);

    // Backpressure: stream 0,1,-1,2 with out_ready low for cycles 2..4.
    stream_in[0] = 32'h0;  stream_exp[0] = 32'h0;
    stream_in[1] = 32'h1;  stream_exp[1] = 32'h1;
    stream_in[2] = 32'hFFFF_FFFF; stream_exp[2] = 32'h8000_0001;
    stream_in[3] = 32'h2;  stream_exp[3] = 32'h2;
    sent = 0; rcvd = 0; held_v = 1'b0; held_d = '0; saw_stall = 1'b0;
    for (int c = 0; c < 20 && rcvd < 4; c++) begin
      @(negedge clk);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? stream_in[sent] : 32'h0;
      out_ready = !(c >= 2 && c <= 4);
      #1;
      if (held_v) chk("bp_hold_stable", out_data, held_d);
      if (out_valid && out_data == 32'h8000_0000) chk("bp_no_neg_zero", out_data, 32'h0);
      if (sent < 4 && !in_ready) saw_stall = 1'b1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        chk("bp_order", out_data, stream_exp[rcvd]);
        rcvd++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (in_fire) sent++;
    end
    chk("bp_all_received", 32'(rcvd), 32'd4);
    chk("bp_in_ready_fell", {31'b0, saw_stall}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // 300 back-to-back overflow words: full throughput, counter saturates.
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 300 && cyc < 400) begin
      in_valid = (sent < 300);
      in_data  = 32'h8000_0000;
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (in_fire) sent++;
      if (out_fire) rcvd++;
      if (out_fire && out_data !== 32'hFFFF_FFFF) chk("stream_sat_data", out_data, 32'hFFFF_FFFF);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_received", 32'(rcvd), 32'd300);
    chk("stream_throughput", {31'b0, (cyc <= 303)}, 32'd1);
    chk("ovf_count_saturated", {24'b0, ovf_count}, 32'h0000_00FF);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0006;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_ovf_count", {24'b0, ovf_count}, 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    rcvd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) rcvd++;
    end
    chk("no_stale_after_rst", 32'(rcvd), 32'd0);
    send_and_check(32'h0000_0005, 32'h0000_0005, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
